// File: rtl/prf_wr_arbiter_pkg.sv
// rtl/prf_wr_arbiter_pkg.sv - PRF write-arbiter sizes, request type and PR decode helpers
package prf_wr_arbiter_pkg;

  localparam int PR_COUNT         = 128;
  localparam int PRF_BANK_COUNT   = 4;
  localparam int PRF_WR_COUNT     = 8;
  localparam int REQ_COUNT        = PRF_WR_COUNT;
  localparam int XLEN             = 32;

  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_PRF_WR_COUNT   = $clog2(PRF_WR_COUNT);
  localparam int PRF_ROW_W          = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [PRF_ROW_W-1:0]          prf_row_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;
  typedef logic [LOG_PRF_WR_COUNT-1:0]   prf_wr_idx_t;
  typedef logic [XLEN-1:0]               xlen_t;

  typedef struct packed {
    logic  valid;
    pr_t   PR;
    xlen_t data;
  } prf_wr_req_t;

  // Banks interleave on the low PR bits so consecutive PRs land in different banks.
  function automatic prf_bank_t pr_bank(input pr_t pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

  function automatic prf_row_t pr_row(input pr_t pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

  function automatic prf_wr_idx_t next_wr_idx(input prf_wr_idx_t idx);
    if (int'(idx) == PRF_WR_COUNT - 1) begin
      return '0;
    end
    return prf_wr_idx_t'(int'(idx) + 1);
  endfunction

endpackage

// File: rtl/prf_wr_arbiter_if.sv
// rtl/prf_wr_arbiter_if.sv - writer request/ready and per-bank PRF write bundle
interface prf_wr_arbiter_if;
  import prf_wr_arbiter_pkg::*;

  logic  [REQ_COUNT-1:0]           req_valid;
  pr_t   [REQ_COUNT-1:0]           req_PR;
  xlen_t [REQ_COUNT-1:0]           req_data;
  logic  [REQ_COUNT-1:0]           req_ready;

  logic     [PRF_BANK_COUNT-1:0]   bank_WEN;
  prf_row_t [PRF_BANK_COUNT-1:0]   bank_row;
  xlen_t    [PRF_BANK_COUNT-1:0]   bank_data;
  pr_t      [PRF_BANK_COUNT-1:0]   bank_PR;

  modport master (
    output req_valid, req_PR, req_data,
    input  req_ready, bank_WEN, bank_row, bank_data, bank_PR
  );

  modport slave (
    input  req_valid, req_PR, req_data,
    output req_ready, bank_WEN, bank_row, bank_data, bank_PR
  );

endinterface

// File: rtl/prf_wr_arbiter_rr_picker.sv
// rtl/prf_wr_arbiter_rr_picker.sv - one-hot round-robin find-first starting at a pointer
module prf_wr_arbiter_rr_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_any_o
);

  localparam int W = $clog2(N);

  always_comb begin
    int j;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    // Walk N slots from the pointer; the first requester seen wins.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!gnt_any_o && req_i[j]) begin
        gnt_any_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = W'(j);
      end
    end
  end

endmodule

// File: rtl/prf_wr_arbiter.sv
// rtl/prf_wr_arbiter.sv - per-bank round-robin arbitration of PR writers onto PRF write ports
// Optional feature macro: PRF_WR_ARB_WR_BUF_PRIORITY_EN (writer 0 always wins its bank).
module prf_wr_arbiter
  import prf_wr_arbiter_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  prf_wr_arbiter_if.slave    wr_if
);

  logic        [PRF_BANK_COUNT-1:0][REQ_COUNT-1:0] cand;
  logic        [PRF_BANK_COUNT-1:0][REQ_COUNT-1:0] pick_gnt;
  prf_wr_idx_t [PRF_BANK_COUNT-1:0]                pick_idx;
  logic        [PRF_BANK_COUNT-1:0]                pick_any;

  logic        [PRF_BANK_COUNT-1:0][REQ_COUNT-1:0] gnt;
  prf_wr_idx_t [PRF_BANK_COUNT-1:0]                gnt_idx;
  logic        [PRF_BANK_COUNT-1:0]                gnt_any;
  logic        [PRF_BANK_COUNT-1:0]                wr_buf_win;

  prf_wr_idx_t [PRF_BANK_COUNT-1:0] rr_ptr_q,    rr_ptr_d;
  logic        [PRF_BANK_COUNT-1:0] bank_wen_q,  bank_wen_d;
  prf_row_t    [PRF_BANK_COUNT-1:0] bank_row_q,  bank_row_d;
  xlen_t       [PRF_BANK_COUNT-1:0] bank_data_q, bank_data_d;
  pr_t         [PRF_BANK_COUNT-1:0] bank_pr_q,   bank_pr_d;

  always_comb begin
    cand = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        cand[b][i] = wr_if.req_valid[i] && (pr_bank(wr_if.req_PR[i]) == prf_bank_t'(b));
      end
    end
  end

  for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
    prf_wr_arbiter_rr_picker #(
      .N (REQ_COUNT)
    ) u_picker (
      .req_i     (cand[gb]),
      .ptr_i     (rr_ptr_q[gb]),
      .gnt_o     (pick_gnt[gb]),
      .gnt_idx_o (pick_idx[gb]),
      .gnt_any_o (pick_any[gb])
    );
  end

  // Grants are suppressed while RST is high so no writer believes it transferred.
  always_comb begin
    gnt        = '0;
    gnt_idx    = '0;
    gnt_any    = '0;
    wr_buf_win = '0;
    if (!RST) begin
      gnt     = pick_gnt;
      gnt_idx = pick_idx;
      gnt_any = pick_any;
`ifdef PRF_WR_ARB_WR_BUF_PRIORITY_EN
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (cand[b][0]) begin
          gnt[b]        = REQ_COUNT'(1);
          gnt_idx[b]    = '0;
          gnt_any[b]    = 1'b1;
          wr_buf_win[b] = 1'b1;
        end
      end
`endif
    end
  end

  always_comb begin
    wr_if.req_ready = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      wr_if.req_ready = wr_if.req_ready | gnt[b];
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    bank_wen_d  = '0;
    bank_row_d  = bank_row_q;
    bank_data_d = bank_data_q;
    bank_pr_d   = bank_pr_q;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (gnt_any[b]) begin
        bank_wen_d[b]  = 1'b1;
        bank_row_d[b]  = pr_row(wr_if.req_PR[gnt_idx[b]]);
        bank_data_d[b] = wr_if.req_data[gnt_idx[b]];
        bank_pr_d[b]   = wr_if.req_PR[gnt_idx[b]];
        // A priority WR_BUF win leaves the rotation where it was.
        if (!wr_buf_win[b]) begin
          rr_ptr_d[b] = next_wr_idx(gnt_idx[b]);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q    <= '0;
      bank_wen_q  <= '0;
      bank_row_q  <= '0;
      bank_data_q <= '0;
      bank_pr_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      bank_wen_q  <= bank_wen_d;
      bank_row_q  <= bank_row_d;
      bank_data_q <= bank_data_d;
      bank_pr_q   <= bank_pr_d;
    end
  end

  assign wr_if.bank_WEN  = bank_wen_q;
  assign wr_if.bank_row  = bank_row_q;
  assign wr_if.bank_data = bank_data_q;
  assign wr_if.bank_PR   = bank_pr_q;

  always_ff @(posedge CLK) begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      assert (RST || $onehot0(gnt[b]))
        else $error("bank %0d granted more than one writer", b);
      assert (RST || ((gnt[b] & ~cand[b]) == '0))
        else $error("bank %0d granted a non-candidate", b);
    end
  end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// tb/tb_prf_wr_arbiter.sv - directed scoreboard bench for prf_wr_arbiter
module tb_prf_wr_arbiter;
  import prf_wr_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  prf_wr_arbiter_if bus ();

  prf_wr_arbiter dut (
    .CLK   (CLK),
    .RST   (RST),
    .wr_if (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    int          bank;
    logic [4:0]  row;
    logic [6:0]  pr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops every write due this cycle and flags any bank write nobody expected.
  always @(negedge CLK) begin
    logic [3:0] seen;
    exp_t e;
    seen = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        chk($sformatf("missed_write_b%0d", e.bank), 64'(e.cyc), 64'(cyc));
      end else begin
        seen[e.bank] = 1'b1;
        chk($sformatf("row_b%0d", e.bank),  64'(bus.bank_row[e.bank]),  64'(e.row));
        chk($sformatf("pr_b%0d", e.bank),   64'(bus.bank_PR[e.bank]),   64'(e.pr));
        chk($sformatf("data_b%0d", e.bank), 64'(bus.bank_data[e.bank]), 64'(e.data));
      end
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      chk($sformatf("wen_b%0d", b), 64'(bus.bank_WEN[b]), 64'(seen[b]));
    end
  end

  task automatic req(input int i, input logic [6:0] pr, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_PR[i]    = pr;
    bus.req_data[i]  = d;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic expect_wr(input int b, input logic [4:0] row, input logic [6:0] pr,
                           input logic [31:0] d);
    exp_q.push_back('{cyc + 1, b, row, pr, d});
  endtask

  task automatic step(input string name, input logic [7:0] exp_ready);
    @(negedge CLK);
    chk(name, 64'(bus.req_ready), 64'(exp_ready));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_PR    = '0;
    bus.req_data  = '0;
    @(posedge CLK);
    #1;
    req(3, 7'h25, 32'hDEADBEEF);
    step("rst_ready", 8'h00);
    chk("rst_row",  64'(bus.bank_row),  64'h0);
    chk("rst_data", 64'(bus.bank_data), 64'h0);
    chk("rst_pr",   64'(bus.bank_PR),   64'h0);
    RST = 1'b0;

    expect_wr(1, 5'd9, 7'h25, 32'hDEADBEEF);
    step("single_rdy", 8'h08);
    drop(3);
    step("idle_a", 8'h00);
    chk("hold_pr_b1",   64'(bus.bank_PR[1]),   64'h25);
    chk("hold_data_b1", 64'(bus.bank_data[1]), 64'hDEADBEEF);

    req(1, 7'h02, 32'h11); req(4, 7'h06, 32'h44); req(6, 7'h0A, 32'h66);
    expect_wr(2, 5'd0, 7'h02, 32'h11); step("rr_w1", 8'h02); drop(1);
    expect_wr(2, 5'd1, 7'h06, 32'h44); step("rr_w4", 8'h10); drop(4);
    expect_wr(2, 5'd2, 7'h0A, 32'h66); step("rr_w6", 8'h40); drop(6);
    req(0, 7'h12, 32'h1000); req(7, 7'h0E, 32'h7777);
    expect_wr(2, 5'd3, 7'h0E, 32'h7777); step("ptr7_w7", 8'h80); drop(7);
    expect_wr(2, 5'd4, 7'h12, 32'h1000); step("ptr7_w0", 8'h01); drop(0);

    req(0, 7'h00, 32'hA0); req(1, 7'h01, 32'hA1); req(2, 7'h02, 32'hA2); req(3, 7'h03, 32'hA3);
    expect_wr(0, 5'd0, 7'h00, 32'hA0);
    expect_wr(1, 5'd0, 7'h01, 32'hA1);
    expect_wr(2, 5'd0, 7'h02, 32'hA2);
    expect_wr(3, 5'd0, 7'h03, 32'hA3);
    step("parallel", 8'h0F);
    drop(0); drop(1); drop(2); drop(3);

    req(6, 7'h04, 32'h6666);
    expect_wr(0, 5'd1, 7'h04, 32'h6666); step("wrap_set", 8'h40); drop(6);
    req(2, 7'h08, 32'h2222); req(7, 7'h0C, 32'h7070);
    expect_wr(0, 5'd3, 7'h0C, 32'h7070); step("wrap_w7", 8'h80); drop(7);
    expect_wr(0, 5'd2, 7'h08, 32'h2222); step("wrap_w2", 8'h04);
    req(2, 7'h10, 32'h2B2B0000);
    expect_wr(0, 5'd4, 7'h10, 32'h2B2B0000); step("b2b_w2", 8'h04); drop(2);
    step("idle_b", 8'h00);

    req(5, 7'h07, 32'h5555);
    expect_wr(3, 5'd1, 7'h07, 32'h5555); step("rst_w5", 8'h20); drop(5);
    RST = 1'b1;
    req(2, 7'h0B, 32'h2B2B); req(6, 7'h0F, 32'h6F6F);
    step("rst_rdy1", 8'h00);
    step("rst_rdy2", 8'h00);
    chk("rst_mid_pr_b3",   64'(bus.bank_PR[3]),   64'h0);
    chk("rst_mid_data_b3", 64'(bus.bank_data[3]), 64'h0);
    RST = 1'b0;
    expect_wr(3, 5'd2, 7'h0B, 32'h2B2B); step("post_rst_w2", 8'h04); drop(2);
    expect_wr(3, 5'd3, 7'h0F, 32'h6F6F); step("post_rst_w6", 8'h40); drop(6);

    req(4, 7'h05, 32'h4545);
    expect_wr(1, 5'd1, 7'h05, 32'h4545); step("pri_set", 8'h10); drop(4);
    req(0, 7'h09, 32'h0A0A); req(5, 7'h0D, 32'h5D5D);
`ifdef PRF_WR_ARB_WR_BUF_PRIORITY_EN
    expect_wr(1, 5'd2, 7'h09, 32'h0A0A); step("pri_w0", 8'h01); drop(0);
    req(1, 7'h11, 32'h1111);
    expect_wr(1, 5'd3, 7'h0D, 32'h5D5D); step("pri_w5", 8'h20); drop(5);
    expect_wr(1, 5'd4, 7'h11, 32'h1111); step("pri_w1", 8'h02); drop(1);
`else
    expect_wr(1, 5'd3, 7'h0D, 32'h5D5D); step("rr_b1_w5", 8'h20); drop(5);
    req(1, 7'h11, 32'h1111);
    expect_wr(1, 5'd2, 7'h09, 32'h0A0A); step("rr_b1_w0", 8'h01); drop(0);
    expect_wr(1, 5'd4, 7'h11, 32'h1111); step("rr_b1_w1", 8'h02); drop(1);
`endif

    step("drain_a", 8'h00);
    step("drain_b", 8'h00);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prf_wr_arbiter.md
# prf_wr_arbiter

Shares the physical register file's per-bank write ports among the core's PR writers: WR_BUF, LDU bank 0, LDU bank 1, ALU Reg-Reg, MDU, ALU Reg-Imm, BRU and SYSU. Each cycle it grants at most one writer per PRF bank, using a round-robin pointer per bank. It then presents a registered write to that bank one cycle later. It sits between the functional-unit writeback stages and the PRF banks.

## Interface
- PR_COUNT, 128, physical register count
- PRF_BANK_COUNT, 4, banks; bank index = low bits of PR
- REQ_COUNT, 8, writers (PRF_WR_COUNT); index 0 is WR_BUF
- XLEN, 32, data width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  [REQ_COUNT]  writer i has a pending write
- req_PR  in  [REQ_COUNT][log2(PR_COUNT)]  destination PR
- req_data  in  [REQ_COUNT][XLEN]  write data
- req_ready  out  [REQ_COUNT]  writer i granted this cycle (combinational)
- bank_WEN  out  [PRF_BANK_COUNT]  registered write enable per bank
- bank_row  out  [PRF_BANK_COUNT][log2(PR_COUNT)-log2(PRF_BANK_COUNT)]  row within the bank
- bank_data  out  [PRF_BANK_COUNT][XLEN]  write data
- bank_PR  out  [PRF_BANK_COUNT][log2(PR_COUNT)]  full PR, for the wakeup broadcast

## Operation
- bank(i) = req_PR[i][log2(PRF_BANK_COUNT)-1:0]. row(i) = the upper bits of req_PR[i].
- Per bank b, the candidate set is every i with req_valid[i] and bank(i)==b.
- The grant goes to the first candidate found searching upward from rr_ptr[b], wrapping from REQ_COUNT-1 to 0.
- Each writer can target only one bank, so it receives at most one grant.
- req_ready[i] = 1 exactly when i is granted. A transfer is the cycle where valid and ready are both high.
- Writer rule: once valid is asserted, it stays asserted with PR and data stable until ready. The arbiter does not check this rule.
- On a grant to i in bank b, rr_ptr[b] ← (i+1) mod REQ_COUNT. A bank with no grant keeps its pointer.
- Output registers load the granted row, data and PR every cycle. bank_WEN[b] ← a grant occurred in bank b.
- When no grant occurs, bank_row, bank_data and bank_PR hold their previous values.
- Starvation bound: a writer holding valid is granted within REQ_COUNT cycles, provided the Configuration option below is not compiled in.
- Reset:
  - rr_ptr = 0 for every bank.
  - bank_WEN = 0; bank_row, bank_data, bank_PR = 0.
  - req_ready = 0 in every cycle RST is high.
  - A write granted the cycle before RST rises has already been registered and still appears. Writes registered during RST are discarded.

## Timing
- Grant to bank write latency: exactly 1 cycle. A grant in cycle t drives bank_WEN in cycle t+1.
- Throughput: PRF_BANK_COUNT writes per cycle when the target banks are all different.
- req_ready depends combinationally on req_valid and req_PR only, never on req_data.
- Back-to-back: a writer granted in cycle t may present a new request in t+1 and compete normally.
- Pointer wrap: a grant to i = REQ_COUNT-1 sets rr_ptr to 0.

## Configuration
- PRF_WR_ARB_WR_BUF_PRIORITY_EN defined:
  - Writer 0 (WR_BUF) always wins its bank, regardless of rr_ptr.
  - rr_ptr is not updated on WR_BUF grants.
  - The starvation bound holds only while WR_BUF is idle on that bank.
- Not defined: writer 0 takes part in round-robin like every other writer.

## Structure
- core_types_pkg adds LOG_PRF_WR_COUNT and typedef prf_wr_req_t (valid, PR, data). The existing PR_COUNT, PRF_BANK_COUNT and PRF_WR_COUNT are reused.
- One sub-module, rr_picker: a REQ_COUNT-wide one-hot round-robin find-first from a pointer. It is instantiated once per bank.
- The top level does the bank decode, per-bank pointer registers, output registers and reset handling.

## Test plan
- Single writer: writer 3 writes PR 0x25 with data 0xDEADBEEF in cycle 5. Expect req_ready[3]=1 in cycle 5, then in cycle 6 bank_WEN=4'b0010, bank_row[1]=9, bank_PR[1]=0x25.
- Bank conflict round-robin, with all rr_ptr=0:
  - Writers 1, 4 and 6 each hold valid to bank 2.
  - Expected grants: 1 in cycle 0, 4 in cycle 1, 6 in cycle 2. Afterward rr_ptr[2]=7.
- Parallel banks: writers 0–3 target PRs 0, 1, 2 and 3. All four are ready in the same cycle, and bank_WEN=4'b1111 the next cycle.
- Wrap-around:
  - Set rr_ptr[0]=7 by granting writer 6.
  - Then writers 2 and 7 both request bank 0. Expect 7 first, rr_ptr[0]=0, then 2.
- Reset mid-operation:
  - Grant writer 5 in cycle t, and assert RST in cycle t+1 while writer 2 holds valid.
  - Expect the cycle t write to appear at t+1, req_ready=0 during RST, and bank_WEN=0 from t+2 until after RST drops.
- With PRF_WR_ARB_WR_BUF_PRIORITY_EN: writers 0 and 5 request bank 1 with rr_ptr[1]=5. Expect writer 0 granted first and rr_ptr[1] to stay at 5.
